// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stalls and branch flushes.
// Define HAZARD_STATS_EN to add the saturating o_stall_count / o_flush_count statistics ports.
module pipeline_hazard_unit #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic [REG_AW-1:0] i_id_dest,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    input  logic              i_branch_taken,
    output logic [1:0]        o_forward_a,
    output logic [1:0]        o_forward_b,
    output logic              o_stall,
    output logic              o_bubble_idex,
    output logic              o_flush_ifid,
    output logic              o_flush_idex,
    output logic              o_flush_exmem
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  o_stall_count,
    output logic [CNT_W-1:0]  o_flush_count
`endif
);

    localparam int unsigned SEQ_W = 3;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              mem_read;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } state_t;

    state_t            r_state;
    logic [SEQ_W-1:0]  r_cnt;
    slot_t             r_ex;
    slot_t             r_mem;
    slot_t             r_wb;

    slot_t             w_id;
    logic              w_load_use;
    logic              w_stall;
    logic              w_flush_ifid;
    logic              w_flush_idex;
    logic              w_flush_exmem;
    logic [1:0]        w_forward_a;
    logic [1:0]        w_forward_b;

    // Newest producer (MEM) wins over the older one (WB); r0 never forwards.
    function automatic logic [1:0] fwd_sel(input slot_t mem, input slot_t wb,
                                           input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (wb.valid && wb.reg_write && (wb.dest != '0) && (wb.dest == src)) begin
            sel = 2'b01;
        end
        if (mem.valid && mem.reg_write && (mem.dest != '0) && (mem.dest == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        w_id           = SLOT_BUBBLE;
        w_id.valid     = i_id_valid;
        w_id.rs        = i_id_rs;
        w_id.rt        = i_id_rt;
        w_id.dest      = i_id_dest;
        w_id.reg_write = i_id_reg_write;
        w_id.mem_read  = i_id_mem_read;
    end

    assign w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.dest != '0) && i_id_valid &&
                        ((r_ex.dest == i_id_rs) || (r_ex.dest == i_id_rt));

    assign w_forward_a = fwd_sel(r_mem, r_wb, r_ex.rs);
    assign w_forward_b = fwd_sel(r_mem, r_wb, r_ex.rt);

    // A taken branch overrides any stall; FLUSH keeps only the fetch slot cleared.
    always_comb begin
        w_stall       = 1'b0;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_flush_exmem = 1'b0;
        if (i_branch_taken) begin
            w_flush_ifid  = 1'b1;
            w_flush_idex  = 1'b1;
            w_flush_exmem = 1'b1;
        end else begin
            case (r_state)
                ST_RUN:   w_stall      = w_load_use;
                ST_STALL: w_stall      = 1'b1;
                ST_FLUSH: w_flush_ifid = 1'b1;
                default:  w_stall      = 1'b0;
            endcase
        end
    end

    // Outputs are forced low while reset is held, whatever the inputs do.
    assign o_forward_a   = i_reset ? w_forward_a : 2'b00;
    assign o_forward_b   = i_reset ? w_forward_b : 2'b00;
    assign o_stall       = i_reset & w_stall;
    assign o_bubble_idex = i_reset & w_stall;
    assign o_flush_ifid  = i_reset & w_flush_ifid;
    assign o_flush_idex  = i_reset & w_flush_idex;
    assign o_flush_exmem = i_reset & w_flush_exmem;

    // Shadow copies of the EX, MEM and WB pipeline registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_ex  <= SLOT_BUBBLE;
            r_mem <= SLOT_BUBBLE;
            r_wb  <= SLOT_BUBBLE;
        end else begin
            r_wb  <= r_mem;
            r_mem <= w_flush_exmem ? SLOT_BUBBLE : r_ex;
            if (i_id_valid && !w_stall && !w_flush_idex) begin
                r_ex <= w_id;
            end else begin
                r_ex <= SLOT_BUBBLE;
            end
        end
    end

    // Sequencer: r_cnt holds the cycles still to run in STALL or FLUSH.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (i_branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
                r_state <= ST_FLUSH;
                r_cnt   <= SEQ_W'(FLUSH_CYCLES - 1);
            end else begin
                r_state <= ST_RUN;
                r_cnt   <= '0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use && (STALL_CYCLES > 1)) begin
                        r_state <= ST_STALL;
                        r_cnt   <= SEQ_W'(STALL_CYCLES - 1);
                    end
                end
                ST_STALL, ST_FLUSH: begin
                    if (r_cnt <= SEQ_W'(1)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - SEQ_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    // Saturating event counters.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (i_branch_taken && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = (CNT_W == 0);
`endif

    // Source fields and load flag are carried into WB for visibility only.
    logic w_unused;
    assign w_unused = ^{r_wb.rs, r_wb.rt, r_wb.mem_read};

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: three instances (1/3-cycle stall, 3-cycle flush)
// driven by shared stimulus; statistics checks are built when HAZARD_STATS_EN is defined.
module tb_pipeline_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_dest;
    logic       id_rw;
    logic       id_mr;
    logic       br;

    logic [1:0] s1_fa, s1_fb, s3_fa, s3_fb, f3_fa, f3_fb;
    logic       s1_stall, s1_bub, s1_fi, s1_fx, s1_fm;
    logic       s3_stall, s3_bub, s3_fi, s3_fx, s3_fm;
    logic       f3_stall, f3_bub, f3_fi, f3_fx, f3_fm;
`ifdef HAZARD_STATS_EN
    logic [15:0] s1_sc, s1_fc, f3_sc, f3_fc;
    logic [1:0]  s3_sc, s3_fc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_unit #(.REG_AW(5), .STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u_s1 (
        .i_clock(clk), .i_reset(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs),
        .i_id_rt(id_rt), .i_id_dest(id_dest), .i_id_reg_write(id_rw), .i_id_mem_read(id_mr),
        .i_branch_taken(br), .o_forward_a(s1_fa), .o_forward_b(s1_fb), .o_stall(s1_stall),
        .o_bubble_idex(s1_bub), .o_flush_ifid(s1_fi), .o_flush_idex(s1_fx),
        .o_flush_exmem(s1_fm)
`ifdef HAZARD_STATS_EN
        , .o_stall_count(s1_sc), .o_flush_count(s1_fc)
`endif
    );

    pipeline_hazard_unit #(.REG_AW(5), .STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(2)) u_s3 (
        .i_clock(clk), .i_reset(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs),
        .i_id_rt(id_rt), .i_id_dest(id_dest), .i_id_reg_write(id_rw), .i_id_mem_read(id_mr),
        .i_branch_taken(br), .o_forward_a(s3_fa), .o_forward_b(s3_fb), .o_stall(s3_stall),
        .o_bubble_idex(s3_bub), .o_flush_ifid(s3_fi), .o_flush_idex(s3_fx),
        .o_flush_exmem(s3_fm)
`ifdef HAZARD_STATS_EN
        , .o_stall_count(s3_sc), .o_flush_count(s3_fc)
`endif
    );

    pipeline_hazard_unit #(.REG_AW(5), .STALL_CYCLES(1), .FLUSH_CYCLES(3), .CNT_W(16)) u_f3 (
        .i_clock(clk), .i_reset(rst_n), .i_id_valid(id_valid), .i_id_rs(id_rs),
        .i_id_rt(id_rt), .i_id_dest(id_dest), .i_id_reg_write(id_rw), .i_id_mem_read(id_mr),
        .i_branch_taken(br), .o_forward_a(f3_fa), .o_forward_b(f3_fb), .o_stall(f3_stall),
        .o_bubble_idex(f3_bub), .o_flush_ifid(f3_fi), .o_flush_idex(f3_fx),
        .o_flush_exmem(f3_fm)
`ifdef HAZARD_STATS_EN
        , .o_stall_count(f3_sc), .o_flush_count(f3_fc)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dest, input logic rw, input logic mr,
                          input logic b);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_dest  = dest;
        id_rw    = rw;
        id_mr    = mr;
        br       = b;
    endtask

    // New ID-stage contents and branch outcome for one cycle; returns mid-cycle.
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dest, input logic rw, input logic mr,
                         input logic b);
        @(negedge clk);
        set_in(v, rs, rt, dest, rw, mr, b);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with live-looking inputs: every output stays low.
        rst_n = 1'b0;
        set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        #12;
        check_eq("rst_fwd", {s1_fa, s1_fb}, 4'b0000);
        check_eq("rst_stall", {s1_stall, s1_bub}, 2'b00);
        check_eq("rst_flush", {s1_fi, s1_fx, s1_fm}, 3'b000);
        check_eq("rst_f3_flush", {f3_fi, f3_fx, f3_fm}, 3'b000);
`ifdef HAZARD_STATS_EN
        check_eq("rst_counts", {s1_sc, s1_fc}, 32'h0);
`endif

        // add r3 ; sub uses r3 as rs ; and uses r3 as rt
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        check_eq("fwd_idle_a", s1_fa, 2'b00);
        drive(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
        check_eq("alu_dep_nostall", s1_stall, 1'b0);
        drive(1'b1, 5'd5, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        check_eq("exmem_fwd_a", s1_fa, 2'b10);
        check_eq("exmem_fwd_b_none", s1_fb, 2'b00);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("memwb_fwd_b", s1_fb, 2'b01);
        check_eq("memwb_fwd_a_none", s1_fa, 2'b00);

        // Two writers of r3 in MEM and WB: the MEM one wins on both operands
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("prio_fwd_a", s1_fa, 2'b10);
        check_eq("prio_fwd_b", s1_fb, 2'b10);

        // lw r5 ; add uses r5, single-cycle stall
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        check_eq("lw_nostall", s1_stall, 1'b0);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("lu1_stall", {s1_stall, s1_bub}, 2'b11);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("lu1_release", {s1_stall, s1_bub}, 2'b00);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("lu1_fwd_wb", s1_fa, 2'b01);

        // Same stimulus with a three-cycle stall, then a second load-use
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        check_eq("lu3_pre", s3_stall, 1'b0);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("lu3_c1", {s3_stall, s3_bub}, 2'b11);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("lu3_c2", {s3_stall, s3_bub}, 2'b11);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("lu3_c3", {s3_stall, s3_bub}, 2'b11);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("lu3_release", s3_stall, 1'b0);
`ifdef HAZARD_STATS_EN
        check_eq("lu3_stall_count", s3_sc, 2'd3);
`endif
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        check_eq("lu3_dep_in_ex_fwd", s3_fa, 2'b00);
        drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        check_eq("lu3b_c1", s3_stall, 1'b1);
        drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        check_eq("lu3b_c3", s3_stall, 1'b1);
        drive(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        check_eq("lu3b_release", s3_stall, 1'b0);
`ifdef HAZARD_STATS_EN
        check_eq("stall_count_sat", s3_sc, 2'd3);
`endif

        // Taken branch in the second cycle of a three-cycle stall
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("br_stall_c1", s3_stall, 1'b1);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1);
        check_eq("br_flush_all", {s3_fi, s3_fx, s3_fm}, 3'b111);
        check_eq("br_no_stall", {s3_stall, s3_bub}, 2'b00);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("br_back_run", {s3_stall, s3_fi}, 2'b00);
`ifdef HAZARD_STATS_EN
        check_eq("br_flush_count", s3_fc, 2'd1);
`endif

        // Three-cycle flush, restart during FLUSH, then reset mid-flush
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check_eq("fl3_c1", {f3_fi, f3_fx, f3_fm}, 3'b111);
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        check_eq("fl3_c2", {f3_fi, f3_fx, f3_fm, f3_stall}, 4'b1000);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("fl3_c3", f3_fi, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("fl3_done", f3_fi, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("fl3b_c2", f3_fi, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check_eq("fl3_restart", {f3_fi, f3_fx, f3_fm}, 3'b111);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("fl3r_c2", {f3_fi, f3_fx}, 2'b10);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("fl3r_c3", f3_fi, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("fl3r_done", f3_fi, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("fl3c_mid", f3_fi, 1'b1);
`ifdef HAZARD_STATS_EN
        check_eq("flush_count_f3", f3_fc, 16'd4);
        check_eq("flush_count_sat", s3_fc, 2'd3);
`endif
        rst_n = 1'b0;
        set_in(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);
        #1;
        check_eq("midrst_f3_out", {f3_fi, f3_fx, f3_fm, f3_stall, f3_bub, f3_fa, f3_fb}, 9'h0);
        check_eq("midrst_s3_out", {s3_fi, s3_fx, s3_fm, s3_stall, s3_bub}, 5'h0);
`ifdef HAZARD_STATS_EN
        check_eq("midrst_f3_counts", {f3_sc, f3_fc}, 32'h0);
        check_eq("midrst_s3_counts", {s3_sc, s3_fc}, 4'h0);
`endif
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("postrst_run", f3_fi, 1'b0);

        // Reset in the middle of a three-cycle stall
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("stlrst_before", s3_stall, 1'b1);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("stlrst_abort", s3_stall, 1'b0);
        drive(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("stlrst_run", s3_stall, 1'b0);

        // lw r0 ; use r0: no stall, no forwarding
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
        check_eq("r0_nostall", {s1_stall, s3_stall}, 2'b00);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("r0_nofwd", s1_fa, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
